// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared FSM type, source limit and one-hot decode for the AXIS round-robin arbiter
package axis_arb_pkg;
    localparam int MAX_SRC = 16;
    localparam int IDX_W = $clog2(MAX_SRC);
    typedef enum logic {IDLE, PKT} state_t;
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < MAX_SRC; i++)
            if (oh[i]) onehot_to_idx = IDX_W'(i);
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot pick of the first requester at or after ptr, wrapping modulo N
module rr_picker
    import axis_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick
);
    // scan from farthest to nearest so the requester closest to ptr overwrites the rest
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) pick = N'(1) << ((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-to-1 AXI-Stream arbiter, round-robin at packet granularity
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 1,
    parameter int DEST_W  = 1,
    parameter int USER_W  = 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_SRC-1:0]           s_tvalid,
    output logic [NUM_SRC-1:0]           s_tready,
    input  logic [NUM_SRC*DATA_W-1:0]    s_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0]  s_tstrb,
    input  logic [NUM_SRC*DATA_W/8-1:0]  s_tkeep,
    input  logic [NUM_SRC-1:0]           s_tlast,
    input  logic [NUM_SRC*ID_W-1:0]      s_tid,
    input  logic [NUM_SRC*DEST_W-1:0]    s_tdest,
    input  logic [NUM_SRC*USER_W-1:0]    s_tuser,
    output logic                         m_tvalid,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tstrb,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic [ID_W-1:0]              m_tid,
    output logic [DEST_W-1:0]            m_tdest,
    output logic [USER_W-1:0]            m_tuser,
    input  logic                         m_tready,
    output logic [NUM_SRC-1:0]           grant,
    output logic                         busy,
    output logic [31:0]                  pkt_count
);
    localparam int KW = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SRC - 1);

    state_t             r_state, w_next;
    logic [NUM_SRC-1:0] r_grant, w_pick;
    logic [IDX_W-1:0]   r_ptr, w_gidx;
    logic [31:0]        r_cnt;
    logic               w_done;

    rr_picker #(.N(NUM_SRC)) u_pick (.req(s_tvalid), .ptr(r_ptr), .pick(w_pick));

    assign w_gidx    = onehot_to_idx(MAX_SRC'(r_grant));
    assign w_done    = m_tvalid && m_tready && m_tlast;
    assign s_tready  = r_grant & {NUM_SRC{m_tready}};
    assign grant     = r_grant;
    assign busy      = (r_state == PKT);
    assign pkt_count = r_cnt;

    // grant is zero outside PKT, so an AND-OR mux also zeroes the idle output
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tstrb  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tid    = '0;
        m_tdest  = '0;
        m_tuser  = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (r_grant[i]) begin
                m_tvalid = s_tvalid[i];
                m_tdata  = s_tdata[i*DATA_W +: DATA_W];
                m_tstrb  = s_tstrb[i*KW +: KW];
                m_tkeep  = s_tkeep[i*KW +: KW];
                m_tlast  = s_tlast[i];
                m_tid    = s_tid[i*ID_W +: ID_W];
                m_tdest  = s_tdest[i*DEST_W +: DEST_W];
                m_tuser  = s_tuser[i*USER_W +: USER_W];
            end
    end

    always_comb begin
        w_next = (r_state == IDLE) ? ((|s_tvalid) ? PKT : IDLE) : (w_done ? IDLE : PKT);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_grant <= w_pick;
            end else if (w_done) begin
                r_grant <= '0;
                r_ptr   <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
                r_cnt   <= r_cnt + 32'd1;
            end
        end
    end
endmodule
